wire_packer: RTL
================

// Module: wire_packer
// PURPOSE
//  Gathers single-bit samples, one per accepted strobe, into a WIDTH-bit word and presents it on a registered output with valid/ready.
//  It is the inverse of splitting a bus into separate wires.
//  Sits between per-leg sense/sequence bit sources and the word-wide consumers of the spider controller.
//  Has a one-word output holding register, so collection of the next word continues while the current word waits.
// PARAMETERS
//  WIDTH      8   bits per output word (>=2)
//  MSB_FIRST  1   1: first accepted bit lands in out_word[WIDTH-1]; 0: first bit lands in out_word[0]
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              reset, asynchronous, active-high
//  in_bit     in   1              sample bit
//  in_valid   in   1              in_bit offered this cycle
//  in_ready   out  1              block can accept in_bit this cycle
//  flush      in   1              emit partial word, zero-padded
//  out_word   out  WIDTH          packed word (registered)
//  out_valid  out  1              out_word holds an unconsumed word
//  out_ready  in   1              consumer takes out_word this cycle
//  bit_count  out  clog2(WIDTH)   bits currently in the shift register (0..WIDTH-1)
//  overrun    out  1              sticky: in_valid seen while in_ready=0
// BEHAVIOUR
//  Reset (async, while rst=1):
//   - shift reg=0, bit_count=0, out_word=0, out_valid=0, overrun=0
//   - in_ready=1 combinationally once rst=0
//  Accept:
//   - transfer when in_valid && in_ready
//   - bit is placed at the position given by MSB_FIRST and bit_count; bit_count increments
//  Completion:
//   - the accept that makes bit_count reach WIDTH is the completing bit
//   - next edge: out_word = full word, out_valid=1, bit_count=0, shift reg cleared
//   - latency: completing bit on edge N, out_valid=1 after edge N (visible cycle N+1)
//  Output slot:
//   - slot_free = !out_valid || out_ready
//   - out_valid clears on out_valid && out_ready, unless a new word loads on the same edge; then out_valid stays 1 with the new word
//   - no bubble when the consumer keeps out_ready=1
//   - out_word is stable while out_valid && !out_ready
//  Backpressure:
//   - in_ready = !(bit_count==WIDTH-1 && !slot_free)
//   - in_ready is combinational from out_ready
//   - the first WIDTH-1 bits of the next word are always accepted
//  Overrun:
//   - in_valid && !in_ready sets overrun=1; the bit is dropped
//   - overrun stays 1 until rst
//  Flush:
//   - sampled each edge; effective only when bit_count>0 (after this cycle's accept) and slot_free
//   - effect: unfilled positions become 0; the word loads to out_word and out_valid=1; bit_count=0
//   - in_valid and flush on the same edge: the bit is accepted first, then the flush applies
//     - if that bit completes the word, it is a normal completion with no extra word
//   - flush with bit_count==0 (after accept) does nothing
//   - flush with !slot_free is ignored; the source holds flush until it takes effect
//  Widths:
//   - bit_count wraps only via completion or flush, never past WIDTH-1
//  No further state:
//   - beyond the shift register, bit_count, the output register and overrun, the block holds no state
// TESTING
//  T1 WIDTH=8, MSB_FIRST=1, out_ready=1: bits 1,0,1,1,0,0,1,0 on consecutive cycles
//     -> one out_valid pulse, out_word=8'hB2, the cycle after the 8th bit
//  T2 MSB_FIRST=0, same bits -> out_word=8'h4D
//  T3 out_ready=0; 16 bits 8'hFF then 8'h0F
//     -> word 1 = 8'hFF held stable; in_ready=0 when bit_count=7; extra in_valid sets overrun=1
//     -> raise out_ready: 8'hFF taken, 8'h0F completes next; overrun stays 1
//  T4 bits 1,1,1 then flush (MSB_FIRST=1) -> out_word=8'hE0, bit_count=0
//     -> flush with bit_count=0 emits nothing
//  T5 7 bits then in_valid+flush on the same edge -> exactly one full word, no zero-padded extra word
//  T6 rst pulsed mid-word (bit_count=5) and with out_valid=1 -> all outputs return to reset values
//     -> next 8 bits form a clean word

Source files
------------

// File: rtl/wire_packer_if.sv
// Handshake bundle for wire_packer: bit-serial input side, word-wide output side.
// master drives samples and consumes words; slave is the packer itself.
interface wire_packer_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH);

   logic             in_bit;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [WIDTH-1:0] out_word;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    bit_count;
   logic             overrun;

   modport master (
      output in_bit, in_valid, flush, out_ready,
      input  in_ready, out_word, out_valid, bit_count, overrun
   );

   modport slave (
      input  in_bit, in_valid, flush, out_ready,
      output in_ready, out_word, out_valid, bit_count, overrun
   );
endinterface

// File: rtl/wire_packer.sv
// wire_packer: collects one bit per accepted strobe into a WIDTH-bit word and
// hands it out through a one-word registered holding slot with valid/ready.
// Collection of the next word proceeds while the current word waits; only the
// last bit position stalls when the slot is still occupied.
// WIDTH must match the WIDTH of the connected wire_packer_if.
module wire_packer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic          clk,
   input logic          rst,
   wire_packer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   // collection stage (p0) and output holding slot (p1)
   logic [WIDTH-1:0] shreg_p0;
   logic [WIDTH-1:0] shreg_nxt;
   logic [CW-1:0]    cnt_p0;
   logic [CW-1:0]    pos;
   logic [CW:0]      cnt_after;
   logic [WIDTH-1:0] word_p1;
   logic             vld_p1;
   logic             ovr_q;

   logic slot_free;
   logic last_slot;
   logic rdy;
   logic accept;
   logic complete;
   logic do_flush;
   logic load;

   // The slot can take a word if empty or being drained on this edge.
   assign slot_free = !vld_p1 || bus.out_ready;
   assign last_slot = (cnt_p0 == CW'(WIDTH - 1));
   // Only the completing bit needs a free slot, so stall just that position.
   assign rdy       = !(last_slot && !slot_free);
   assign accept    = bus.in_valid && rdy;
   assign complete  = accept && last_slot;
   assign cnt_after = {1'b0, cnt_p0} + {{CW{1'b0}}, accept};
   // Flush sees the count after this cycle's accept; a completing bit already
   // emits the word, so flush must not produce a second (padded) one.
   assign do_flush  = bus.flush && !complete && (cnt_after != '0) && slot_free;
   assign load      = complete || do_flush;

   // Place the incoming bit at its slot; unfilled slots stay zero for flush padding.
   always_comb begin
      pos       = MSB_FIRST ? (CW'(WIDTH - 1) - cnt_p0) : cnt_p0;
      shreg_nxt = shreg_p0;
      if (accept) begin
         shreg_nxt[pos] = bus.in_bit;
      end
   end

   // Collection register: advance on accept, clear whenever a word is handed out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_p0 <= '0;
         cnt_p0   <= '0;
      end else if (load) begin
         shreg_p0 <= '0;
         cnt_p0   <= '0;
      end else begin
         shreg_p0 <= shreg_nxt;
         cnt_p0   <= cnt_after[CW-1:0];
      end
   end

   // Output slot: a load on the draining edge keeps valid high with the new word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_p1 <= '0;
         vld_p1  <= 1'b0;
      end else if (load) begin
         word_p1 <= shreg_nxt;
         vld_p1  <= 1'b1;
      end else if (vld_p1 && bus.out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   // Sticky flag for a sample offered while the last position was stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_q <= 1'b0;
      end else if (bus.in_valid && !rdy) begin
         ovr_q <= 1'b1;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_word  = word_p1;
   assign bus.out_valid = vld_p1;
   assign bus.bit_count = cnt_p0;
   assign bus.overrun   = ovr_q;
endmodule
